// File: rtl/mio_arbiter_pkg.sv
// Shared types for the two-master memory/IO port arbiter.
package mio_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic M_CPU = 1'b0;
  localparam logic M_AUX = 1'b1;

endpackage

// File: rtl/mio_rr_pick.sv
// Combinational two-way picker: fixed CPU priority or round-robin on ties.
module mio_rr_pick
  import mio_arbiter_pkg::*;
#(
  parameter bit CPU_PRIO = 1'b0
) (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic valid,
  output logic winner
);

  assign valid = req0 | req1;

  // On a tie the master that did not own the previous access wins unless the CPU is favoured
  always_comb begin
    winner = M_CPU;
    if (req0 && req1) begin
      winner = CPU_PRIO ? M_CPU : ~last_grant;
    end else if (req1) begin
      winner = M_AUX;
    end
  end

endmodule

// File: rtl/mio_arbiter.sv
// Two-master arbiter and fixed-latency access sequencer for the CPU memory/IO port.
module mio_arbiter
  import mio_arbiter_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MEM_LAT  = 1,
  parameter bit CPU_PRIO = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_ready,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_ready,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic          grant,
  output logic          busy
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          last_grant;
  logic          pick_valid;
  logic          pick_winner;

  mio_rr_pick #(
    .CPU_PRIO(CPU_PRIO)
  ) u_pick (
    .req0      (m0_req),
    .req1      (m1_req),
    .last_grant(last_grant),
    .valid     (pick_valid),
    .winner    (pick_winner)
  );

  // mem_addr/mem_wdata double as the latched request, so they stay stable for the whole access
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= M_AUX;
      grant      <= M_CPU;
      busy       <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      m0_ready   <= 1'b0;
      m1_ready   <= 1'b0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
    end else begin
      mem_we   <= 1'b0;
      m0_ready <= 1'b0;
      m1_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant      <= pick_winner;
            last_grant <= pick_winner;
            mem_addr   <= (pick_winner == M_AUX) ? m1_addr  : m0_addr;
            mem_wdata  <= (pick_winner == M_AUX) ? m1_wdata : m0_wdata;
            mem_we     <= (pick_winner == M_AUX) ? m1_we    : m0_we;
            cnt        <= CNT_LOAD;
            busy       <= 1'b1;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            if (grant == M_AUX) begin
              m1_rdata <= mem_rdata;
              m1_ready <= 1'b1;
            end else begin
              m0_rdata <= mem_rdata;
              m0_ready <= 1'b1;
            end
            state <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mio_arbiter.sv
// Self-checking bench: three arbiter configurations share one stimulus and a timeline-based model.
module tb_mio_arbiter;

  localparam int N = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;

  logic [N-1:0][31:0] m0_rdata_w, m1_rdata_w, mem_addr_w, mem_wdata_w, mem_rdata_s;
  logic [N-1:0]       m0_ready_w, m1_ready_w, mem_we_w, grant_w, busy_w;

  int checks = 0;
  int errors = 0;

  function automatic int lat_of(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic bit prio_of(int k);
    return (k == 2);
  endfunction

  genvar g;
  generate
    for (g = 0; g < N; g++) begin : g_dut
      mio_arbiter #(
        .AW(32), .DW(32), .MEM_LAT(g == 0 ? 1 : 3), .CPU_PRIO(g == 2)
      ) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata_w[g]), .m0_ready(m0_ready_w[g]),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata_w[g]), .m1_ready(m1_ready_w[g]),
        .mem_addr(mem_addr_w[g]), .mem_wdata(mem_wdata_w[g]), .mem_we(mem_we_w[g]),
        .mem_rdata(mem_rdata_s[g]), .grant(grant_w[g]), .busy(busy_w[g])
      );
    end
  endgenerate

  // Model: each access is a grant edge plus a fixed timeline of LAT+2 cycles
  int          cyc = 0;
  int          free_at [N];
  int          g_edge  [N];
  bit          has_acc [N];
  bit          g_who   [N];
  bit          g_we    [N];
  logic [31:0] g_addr  [N];
  logic [31:0] g_wdata [N];
  bit          last    [N];
  logic [31:0] exp_rdata [N][2];
  logic [31:0] mem [N][64];
  bit          e_busy [N], e_we [N], e_rdy0 [N], e_rdy1 [N];

  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int k = 0; k < N; k++) begin
      int L;
      bit w;
      L = lat_of(k);
      if (reset) begin
        free_at[k] = cyc + 1;
        has_acc[k] = 1'b0;
        g_who[k] = 1'b0;
        g_we[k] = 1'b0;
        g_addr[k] = '0;
        g_wdata[k] = '0;
        last[k] = 1'b1;
        exp_rdata[k][0] = '0;
        exp_rdata[k][1] = '0;
      end else begin
        if (has_acc[k] && cyc == g_edge[k] + 1 && g_we[k])
          mem[k][g_addr[k][7:2]] = g_wdata[k];
        if (has_acc[k] && cyc == g_edge[k] + L)
          exp_rdata[k][g_who[k]] = mem_rdata_s[k];
        if (cyc >= free_at[k] && (m0_req || m1_req)) begin
          if (m0_req && m1_req) w = prio_of(k) ? 1'b0 : !last[k];
          else w = m1_req;
          has_acc[k] = 1'b1;
          g_edge[k] = cyc;
          g_who[k] = w;
          g_we[k] = w ? m1_we : m0_we;
          g_addr[k] = w ? m1_addr : m0_addr;
          g_wdata[k] = w ? m1_wdata : m0_wdata;
          last[k] = w;
          free_at[k] = cyc + L + 2;
        end
      end
      e_busy[k] = has_acc[k] && cyc >= g_edge[k] && cyc <= g_edge[k] + L;
      e_we[k]   = has_acc[k] && cyc == g_edge[k] && g_we[k];
      e_rdy0[k] = has_acc[k] && cyc == g_edge[k] + L && !g_who[k];
      e_rdy1[k] = has_acc[k] && cyc == g_edge[k] + L && g_who[k];
      mem_rdata_s[k] <= (has_acc[k] && cyc == g_edge[k] + L - 1) ? mem[k][g_addr[k][7:2]] : $urandom;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                               input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      checkOutput($sformatf("busy[%0d]", k), 32'(busy_w[k]), 32'(e_busy[k]));
      checkOutput($sformatf("mem_we[%0d]", k), 32'(mem_we_w[k]), 32'(e_we[k]));
      checkOutput($sformatf("mem_addr[%0d]", k), mem_addr_w[k], g_addr[k]);
      checkOutput($sformatf("mem_wdata[%0d]", k), mem_wdata_w[k], g_wdata[k]);
      checkOutput($sformatf("grant[%0d]", k), 32'(grant_w[k]), 32'(g_who[k]));
      checkOutput($sformatf("m0_ready[%0d]", k), 32'(m0_ready_w[k]), 32'(e_rdy0[k]));
      checkOutput($sformatf("m1_ready[%0d]", k), 32'(m1_ready_w[k]), 32'(e_rdy1[k]));
      checkOutput($sformatf("m0_rdata[%0d]", k), m0_rdata_w[k], exp_rdata[k][0]);
      checkOutput($sformatf("m1_rdata[%0d]", k), m1_rdata_w[k], exp_rdata[k][1]);
    end
  end

  int own_q[$];
  int at_q[$];
  int c2_m0, c2_m1;

  initial begin
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < 64; i++) mem[k][i] = 32'hA500_0000 + 32'(i * 17);
      mem[k][4] = 32'hDEAD_BEEF;
    end
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    // Reset held two cycles, then idle
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset busy", 32'(busy_w), 32'h0);
    checkOutput("reset grant", 32'(grant_w), 32'h0);
    checkOutput("reset ready", 32'({m0_ready_w, m1_ready_w}), 32'h0);
    checkOutput("reset mem_addr", mem_addr_w[1], 32'h0);

    // CPU read of 0x10
    applyStimulus(1, 0, 32'h10, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("rd mem_addr", mem_addr_w[0], 32'h10);
    checkOutput("rd mem_we", 32'(mem_we_w[0]), 32'h0);
    checkOutput("rd early ready", 32'(m0_ready_w[0]), 32'h0);
    @(negedge clk);
    checkOutput("rd ready", 32'(m0_ready_w[0]), 32'h1);
    checkOutput("rd rdata", m0_rdata_w[0], 32'hDEAD_BEEF);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("rd ready single", 32'(m0_ready_w[0]), 32'h0);
    checkOutput("rd rdata hold", m0_rdata_w[0], 32'hDEAD_BEEF);
    repeat (4) @(negedge clk);
    checkOutput("rd rdata lat3", m0_rdata_w[1], 32'hDEAD_BEEF);

    // CPU write of 0x1234_5678 to 0x20, then read it back
    applyStimulus(1, 1, 32'h20, 32'h1234_5678, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("wr mem_we", 32'(mem_we_w[0]), 32'h1);
    checkOutput("wr mem_addr", mem_addr_w[0], 32'h20);
    checkOutput("wr mem_wdata", mem_wdata_w[0], 32'h1234_5678);
    @(negedge clk);
    checkOutput("wr mem_we once", 32'(mem_we_w[0]), 32'h0);
    checkOutput("wr ready", 32'(m0_ready_w[0]), 32'h1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (5) @(negedge clk);
    applyStimulus(1, 0, 32'h20, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    checkOutput("wr readback", m0_rdata_w[0], 32'h1234_5678);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (5) @(negedge clk);

    // Contention with both requests held for four accesses
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1, 0, 32'h40, 0, 1, 0, 32'h80, 0);
    c2_m0 = 0;
    c2_m1 = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      checkOutput("ready overlap", 32'(m0_ready_w[1] & m1_ready_w[1]), 32'h0);
      if (m0_ready_w[1] || m1_ready_w[1]) begin
        own_q.push_back(m1_ready_w[1] ? 1 : 0);
        at_q.push_back(i);
      end
      if (m0_ready_w[2]) c2_m0++;
      if (m1_ready_w[2]) c2_m1++;
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rr pulses", 32'(own_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < own_q.size()) begin
        checkOutput($sformatf("rr owner %0d", i), 32'(own_q[i]), 32'(i % 2));
        checkOutput($sformatf("rr time %0d", i), 32'(at_q[i]), 32'(4 + 5 * i));
      end
    end
    checkOutput("prio m0 pulses", 32'(c2_m0), 32'd4);
    checkOutput("prio m1 pulses", 32'(c2_m1), 32'd0);
    repeat (6) @(negedge clk);

    // Reset in the second BUSY cycle of a CPU write
    applyStimulus(1, 1, 32'h30, 32'hCAFE_0000, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("abort mem_we", 32'(mem_we_w[1]), 32'h1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort busy", 32'(busy_w[1]), 32'h0);
    checkOutput("abort mem_we off", 32'(mem_we_w[1]), 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("abort no ready", 32'(m0_ready_w[1]), 32'h0);
    end
    applyStimulus(1, 0, 32'h4, 0, 1, 0, 32'h8, 0);
    @(negedge clk);
    checkOutput("abort last_grant", 32'(grant_w[1]), 32'h0);
    repeat (3) @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (6) @(negedge clk);

    // Master 1 drops its request right after the grant
    applyStimulus(0, 0, 0, 0, 1, 0, 32'h50, 0);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 1) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput($sformatf("drop m1_ready t%0d", i), 32'(m1_ready_w[1]), 32'(i == 4));
    end
    repeat (4) @(negedge clk);

    // Randomized traffic with occasional reset
    $display("[TB] random phase");
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 299) == 0);
      applyStimulus($urandom_range(0, 9) < 7, 1'($urandom), 32'($urandom_range(0, 255)), $urandom,
                    $urandom_range(0, 9) < 6, 1'($urandom), 32'($urandom_range(0, 255)), $urandom);
    end
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (8) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
